// File: rtl/lsu_pkg.sv
// Shared types and default sizing for the load/store memory-access stage.
package lsu_pkg;
    localparam int LSU_DATA_W  = 16;
    localparam int LSU_ADDR_W  = 16;
    localparam int LSU_REG_W   = 3;
    localparam int LSU_TIMEOUT = 15;
    localparam int LSU_CNT_W   = 8;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } lsu_state_t;

    typedef enum logic {
        LD = 1'b0,
        ST = 1'b1
    } lsu_op_t;
endpackage

// File: rtl/lsu_timeout_ctr.sv
// Wait-cycle counter: cleared while idle, advances on each unacknowledged wait
// cycle, flags expiry when the last allowed wait cycle is being sampled.
module lsu_timeout_ctr
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = LSU_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expired
);
    localparam logic [LSU_CNT_W-1:0] C_LAST = LSU_CNT_W'(TIMEOUT - 1);

    logic [LSU_CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (r_count == C_LAST);
endmodule

// File: rtl/lsu_mem_stage.sv
// Memory-access stage: issues one req/ack word transaction per load/store,
// stalls the core while it is outstanding and aborts it on a bounded ack wait.
module lsu_mem_stage
    import lsu_pkg::*;
#(
    parameter int DATA_W  = LSU_DATA_W,
    parameter int ADDR_W  = LSU_ADDR_W,
    parameter int REG_W   = LSU_REG_W,
    parameter int TIMEOUT = LSU_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid,
    input  logic              op_load,
    input  logic              op_store,
    input  logic [ADDR_W-1:0] op_addr,
    input  logic [DATA_W-1:0] op_wdata,
    input  logic [REG_W-1:0]  op_rd,
    output logic              busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_data,
    output logic [REG_W-1:0]  wb_reg,
    output logic              st_done,
    output logic              fault
);
    lsu_state_t        r_state;
    lsu_state_t        w_state_next;
    lsu_op_t           r_kind;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [REG_W-1:0]  r_rd;
    logic              r_wb_valid;
    logic [DATA_W-1:0] r_wb_data;
    logic [REG_W-1:0]  r_wb_reg;
    logic              r_st_done;
    logic              r_fault;

    logic w_accept;
    logic w_ctr_clear;
    logic w_ctr_en;
    logic w_expired;
    logic w_wb_valid_next;
    logic w_st_done_next;
    logic w_fault_next;

    lsu_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_ctr_clear),
        .i_en      (w_ctr_en),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_accept        = 1'b0;
        w_ctr_clear     = 1'b0;
        w_ctr_en        = 1'b0;
        w_wb_valid_next = 1'b0;
        w_st_done_next  = 1'b0;
        w_fault_next    = 1'b0;
        case (r_state)
            IDLE: begin
                w_ctr_clear = 1'b1;
                if (op_valid) begin
                    if (op_load ^ op_store) begin
                        w_accept     = 1'b1;
                        w_state_next = WAIT;
                    end else if (op_load && op_store) begin
                        w_fault_next = 1'b1;
                    end
                end
            end
            WAIT: begin
                // An ack on the expiry cycle still completes normally.
                if (mem_ack) begin
                    w_state_next    = IDLE;
                    w_wb_valid_next = (r_kind == LD);
                    w_st_done_next  = (r_kind == ST);
                end else if (w_expired) begin
                    w_state_next = IDLE;
                    w_fault_next = 1'b1;
                end else begin
                    w_ctr_en = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_kind      <= LD;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rd        <= '0;
            r_wb_valid  <= 1'b0;
            r_wb_data   <= '0;
            r_wb_reg    <= '0;
            r_st_done   <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_wb_valid <= w_wb_valid_next;
            r_st_done  <= w_st_done_next;
            r_fault    <= w_fault_next;
            if (w_accept) begin
                r_kind      <= op_store ? ST : LD;
                r_mem_we    <= op_store;
                r_mem_addr  <= op_addr;
                r_mem_wdata <= op_wdata;
                r_rd        <= op_rd;
            end
            if (w_wb_valid_next) begin
                r_wb_data <= mem_rdata;
                r_wb_reg  <= r_rd;
            end
        end
    end

    // The request is simply "in WAIT", so an async reset drops it at once.
    assign mem_req   = (r_state == WAIT);
    assign busy      = (r_state == WAIT);
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign wb_valid  = r_wb_valid;
    assign wb_data   = r_wb_data;
    assign wb_reg    = r_wb_reg;
    assign st_done   = r_st_done;
    assign fault     = r_fault;
endmodule

// File: tb/tb_lsu_mem_stage.sv
// Self-checking bench for lsu_mem_stage: vector table, hand sequences for
// timeout/reset/back-to-back, and randomized ops against a transaction model.
module tb_lsu_mem_stage;
    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_valid, op_load, op_store;
    logic [15:0] op_addr, op_wdata;
    logic [2:0]  op_rd;
    logic        busy, mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        wb_valid;
    logic [15:0] wb_data;
    logic [2:0]  wb_reg;
    logic        st_done, fault;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] prev_wbd;
    logic [2:0]  prev_wbr;

    typedef struct {
        logic        ld;
        logic        st;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [2:0]  rd;
        int          dly;      // ack presented on the dly-th wait cycle; 0 = never
        logic [15:0] rdata;
        int          e_req;
        logic        e_wbv;
        logic        e_st;
        logic        e_flt;
    } vec_t;

    vec_t vecs[8];
    logic [15:0] b_data[200];

    lsu_mem_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op_valid  (op_valid),
        .op_load   (op_load),
        .op_store  (op_store),
        .op_addr   (op_addr),
        .op_wdata  (op_wdata),
        .op_rd     (op_rd),
        .busy      (busy),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .wb_valid  (wb_valid),
        .wb_data   (wb_data),
        .wb_reg    (wb_reg),
        .st_done   (st_done),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic ld, input logic st, input logic [15:0] addr,
                                input logic [15:0] wdata, input logic [2:0] rd, input int dly,
                                input logic [15:0] rdata, input int e_req, input logic e_wbv,
                                input logic e_st, input logic e_flt);
        vec_t v;
        v.ld = ld; v.st = st; v.addr = addr; v.wdata = wdata; v.rd = rd;
        v.dly = dly; v.rdata = rdata;
        v.e_req = e_req; v.e_wbv = e_wbv; v.e_st = e_st; v.e_flt = e_flt;
        return v;
    endfunction

    // Transaction-level reference: outcome depends only on op kind and ack delay.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        r.e_req = 0; r.e_wbv = 1'b0; r.e_st = 1'b0; r.e_flt = 1'b0;
        if (v.ld && v.st) begin
            r.e_flt = 1'b1;
        end else if (v.ld || v.st) begin
            if (v.dly >= 1 && v.dly <= TO) begin
                r.e_req = v.dly;
                r.e_wbv = v.ld;
                r.e_st  = v.st;
            end else begin
                r.e_req = TO;
                r.e_flt = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic do_op(input vec_t v, output int req_n, output int wbv_n,
                         output int st_n, output int flt_n, output logic stable_ok);
        op_valid = 1'b1; op_load = v.ld; op_store = v.st;
        op_addr = v.addr; op_wdata = v.wdata; op_rd = v.rd; mem_ack = 1'b0;
        @(posedge clk); #1;
        op_valid = 1'b0; op_load = 1'b0; op_store = 1'b0;
        op_addr = 16'($urandom); op_wdata = 16'($urandom); op_rd = 3'($urandom);
        req_n = 0; wbv_n = 0; st_n = 0; flt_n = 0; stable_ok = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            wbv_n += int'(wb_valid);
            st_n  += int'(st_done);
            flt_n += int'(fault);
            if (!mem_req) begin
                if (busy !== 1'b0) stable_ok = 1'b0;
                break;
            end
            req_n++;
            if (mem_addr !== v.addr || mem_wdata !== v.wdata || mem_we !== v.st || busy !== 1'b1)
                stable_ok = 1'b0;
            if (k == v.dly) begin
                mem_ack = 1'b1; mem_rdata = v.rdata;
            end else begin
                mem_ack = 1'b0; mem_rdata = 16'($urandom);
            end
            @(posedge clk); #1;
            mem_ack = 1'b0;
        end
        @(posedge clk); #1;
        wbv_n += int'(wb_valid);
        st_n  += int'(st_done);
        flt_n += int'(fault);
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int req_n, wbv_n, st_n, flt_n;
        logic stable_ok;
        do_op(v, req_n, wbv_n, st_n, flt_n, stable_ok);
        if (v.e_wbv) begin
            prev_wbd = v.rdata;
            prev_wbr = v.rd;
        end
        $display("%s ld=%0b st=%0b addr=%h dly=%0d req=%0d wbv=%0d st_done=%0d fault=%0d",
                 tag, v.ld, v.st, v.addr, v.dly, req_n, wbv_n, st_n, flt_n);
        chk({tag, "_req_cycles"}, 64'(req_n), 64'(v.e_req));
        chk({tag, "_wb_pulses"}, 64'(wbv_n), 64'(v.e_wbv));
        chk({tag, "_st_pulses"}, 64'(st_n), 64'(v.e_st));
        chk({tag, "_fault_pulses"}, 64'(flt_n), 64'(v.e_flt));
        chk({tag, "_stable"}, 64'(stable_ok), 64'(1));
        chk({tag, "_wb_data"}, 64'(wb_data), 64'(prev_wbd));
        chk({tag, "_wb_reg"}, 64'(wb_reg), 64'(prev_wbr));
    endtask

    initial begin
        int n, pulses, issued, cyc, cyc_last, bad, faults;
        vec_t v;

        rst_n = 1'b1; op_valid = 1'b0; op_load = 1'b0; op_store = 1'b0;
        op_addr = '0; op_wdata = '0; op_rd = '0; mem_ack = 1'b0; mem_rdata = '0;
        prev_wbd = '0; prev_wbr = '0;

        // Reset state
        #2 rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("reset_outputs", 64'({busy, mem_req, mem_we, mem_addr, mem_wdata, wb_valid,
                                  wb_data, wb_reg, st_done, fault}), 64'(0));
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_idle", 64'({busy, mem_req, mem_addr, mem_wdata, fault}), 64'(0));

        vecs[0] = mk(1, 0, 16'h0105, 16'h0000, 3'd3, 1,  16'hBEEF, 1,  1, 0, 0);
        vecs[1] = mk(0, 1, 16'hFFFF, 16'h1234, 3'd0, 4,  16'h0000, 4,  0, 1, 0);
        vecs[2] = mk(1, 0, 16'h0040, 16'h0000, 3'd5, 0,  16'h0000, 15, 0, 0, 1);
        vecs[3] = mk(1, 1, 16'h0050, 16'h0000, 3'd1, 1,  16'h1111, 0,  0, 0, 1);
        vecs[4] = mk(0, 0, 16'h0060, 16'h0000, 3'd2, 1,  16'h2222, 0,  0, 0, 0);
        vecs[5] = mk(1, 0, 16'h7FFE, 16'h0000, 3'd6, 15, 16'hCAFE, 15, 1, 0, 0);
        vecs[6] = mk(0, 1, 16'h0002, 16'hAAAA, 3'd0, 16, 16'h0000, 15, 0, 0, 1);
        vecs[7] = mk(1, 0, 16'h8000, 16'h0000, 3'd7, 2,  16'h5A5A, 2,  1, 0, 0);
        for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Timeout followed by an op on the very next edge
        op_valid = 1'b1; op_load = 1'b1; op_addr = 16'h0123; op_rd = 3'd2;
        @(posedge clk); #1;
        op_valid = 1'b0; op_load = 1'b0;
        n = 0;
        for (int k = 0; k < 20 && mem_req; k++) begin
            n++;
            @(posedge clk); #1;
        end
        $display("timeout load req_cycles=%0d fault=%0b", n, fault);
        chk("to_req_cycles", 64'(n), 64'(TO));
        chk("to_fault", 64'(fault), 64'(1));
        chk("to_no_wb", 64'(wb_valid), 64'(0));
        op_valid = 1'b1; op_store = 1'b1; op_addr = 16'h0200; op_wdata = 16'h55AA;
        @(posedge clk); #1;
        op_valid = 1'b0; op_store = 1'b0;
        $display("post-timeout store req=%0b we=%0b", mem_req, mem_we);
        chk("to_next_accept", 64'({mem_req, mem_we, mem_addr, mem_wdata}), {44'd0, 2'b11, 16'h0200, 16'h55AA} >> 0);
        chk("to_fault_one_cycle", 64'(fault), 64'(0));
        mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        chk("to_next_st_done", 64'(st_done), 64'(1));
        @(posedge clk); #1;
        chk("to_next_st_done_drop", 64'(st_done), 64'(0));

        // Ack while idle
        mem_ack = 1'b1; mem_rdata = 16'hFFFF;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(posedge clk); #1;
        $display("idle ack req=%0b wbv=%0b", mem_req, wb_valid);
        chk("idle_ack_quiet", 64'({mem_req, busy, wb_valid, st_done, fault}), 64'(0));
        chk("idle_ack_wb_hold", 64'({wb_data, wb_reg}), 64'({prev_wbd, prev_wbr}));

        // Reset in the middle of a pending load
        op_valid = 1'b1; op_load = 1'b1; op_addr = 16'h0F0F; op_rd = 3'd4;
        @(posedge clk); #1;
        op_valid = 1'b0; op_load = 1'b0;
        chk("rst_mid_req_before", 64'(mem_req), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        $display("reset mid-wait req=%0b busy=%0b", mem_req, busy);
        chk("rst_mid_outputs", 64'({busy, mem_req, mem_we, mem_addr, mem_wdata, wb_valid,
                                    wb_data, wb_reg, st_done, fault}), 64'(0));
        @(posedge clk); #3 rst_n = 1'b1;
        prev_wbd = '0; prev_wbr = '0;
        mem_ack = 1'b1; mem_rdata = 16'h7777;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        n = 0;
        for (int k = 0; k < 3; k++) begin
            n += int'(wb_valid) + int'(fault) + int'(st_done) + int'(mem_req);
            @(posedge clk); #1;
        end
        chk("rst_mid_no_completion", 64'(n), 64'(0));

        // 200 back-to-back loads with immediate ack
        for (int i = 0; i < 200; i++) b_data[i] = 16'($urandom);
        pulses = 0; issued = 0; cyc = 0; cyc_last = -1; bad = 0; faults = 0;
        while (pulses < 200 && cyc < 1000) begin
            if (wb_valid) begin
                if (wb_data !== b_data[pulses] || wb_reg !== 3'(pulses % 8)) bad++;
                $display("b2b load %0d data=%h reg=%0d", pulses, wb_data, wb_reg);
                pulses++;
                if (pulses == 200) cyc_last = cyc;
            end
            faults += int'(fault);
            if (!mem_req && issued < 200) begin
                op_valid = 1'b1; op_load = 1'b1; op_addr = 16'($urandom);
                op_rd = 3'(issued % 8); mem_ack = 1'b0;
                issued++;
            end else if (mem_req) begin
                op_valid = 1'b0; op_load = 1'b0;
                mem_ack = 1'b1; mem_rdata = b_data[issued - 1];
            end else begin
                op_valid = 1'b0; op_load = 1'b0; mem_ack = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        op_valid = 1'b0; op_load = 1'b0; mem_ack = 1'b0;
        chk("b2b_pulses", 64'(pulses), 64'(200));
        chk("b2b_data_errors", 64'(bad), 64'(0));
        chk("b2b_cycles", 64'(cyc_last), 64'(400));
        chk("b2b_no_fault", 64'(faults), 64'(0));
        prev_wbd = b_data[199];
        prev_wbr = 3'(199 % 8);
        @(posedge clk); #1;

        // Randomized ops against the transaction model
        for (int i = 0; i < 150; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            v.ld    = (r == 0) ? 1'b1 : (r == 1) ? 1'b0 : r[0];
            v.st    = (r == 0) ? 1'b1 : (r == 1) ? 1'b0 : ~r[0];
            v.addr  = 16'($urandom);
            v.wdata = 16'($urandom);
            v.rd    = 3'($urandom);
            v.dly   = int'($urandom_range(0, 18));
            v.rdata = 16'($urandom);
            v = model(v);
            run_vec($sformatf("rnd%0d", i), v);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
Memory-access stage directly downstream of the L-type ALU. It takes the effective address produced by that ALU (register + sign-extended 9-bit immediate) and drives one word transaction on the data-memory port using a req/ack handshake. For loads it returns the read word to register writeback. It stalls the core while a transaction is outstanding and aborts any transaction that exceeds a bounded ack wait.

Parameters:
DATA_W, 16, data word width
ADDR_W, 16, word address width (equals the ALU output width)
REG_W, 3, destination register index width
TIMEOUT, 15, maximum cycles mem_req stays high without mem_ack before abort (1..2^8-1)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
op_valid  in  1  operation presented this cycle
op_load  in  1  operation is a load
op_store  in  1  operation is a store
op_addr  in  ADDR_W  effective address from the L-type ALU, two's-complement sum taken as unsigned
op_wdata  in  DATA_W  store data
op_rd  in  REG_W  load destination register
busy  out  1  transaction in progress; core must hold its inputs and stall
mem_req  out  1  memory request
mem_we  out  1  1 = write, 0 = read
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_ack  in  1  memory completion; mem_rdata valid in the same cycle
mem_rdata  in  DATA_W  memory read data
wb_valid  out  1  one-cycle pulse: load data ready
wb_data  out  DATA_W  loaded word
wb_reg  out  REG_W  destination index
st_done  out  1  one-cycle pulse: store acknowledged
fault  out  1  one-cycle pulse: illegal op or timeout

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE, counter 0, all outputs 0. Reset mid-transaction drops mem_req immediately. No wb_valid, st_done or fault is produced for the aborted operation.
- States: IDLE, WAIT.
- IDLE: busy=0, mem_req=0. At a clock edge with op_valid=1:
  - Exactly one of op_load/op_store set: register op_addr, op_wdata, op_rd and the op kind. Go to WAIT with mem_req=1, mem_we=op_store, counter=0.
  - Both set: fault=1 for one cycle, no request, stay IDLE.
  - Neither set: ignored.
  - mem_ack in IDLE: ignored.
- WAIT: busy=1. mem_req, mem_we, mem_addr and mem_wdata are held stable. op_* inputs are ignored.
  - Edge with mem_ack=1: mem_req←0, go to IDLE.
    - Load: wb_valid←1, wb_data←mem_rdata, wb_reg←latched rd.
    - Store: st_done←1.
  - Edge with mem_ack=0: counter increments. When the counter reaches TIMEOUT-1 with no ack: mem_req←0, fault←1, go to IDLE, no writeback.
  - An ack arriving on the same edge as timeout expiry wins: normal completion, no fault.
- Latency: op accepted at edge N → mem_req high after N → earliest ack sampled at N+1 → wb_valid/st_done high for the cycle after N+1. Throughput is at most one op per 2 cycles. A new op may be accepted on the edge after completion (state is IDLE by then).
- Pulses: wb_valid, st_done and fault are high for exactly one cycle. wb_data and wb_reg hold their values until the next load completes.
- Width rules: no address arithmetic in this block; op_addr passes through bit-exact, so negative ALU sums appear as high addresses (e.g. -1 → 16'hFFFF). mem_addr and mem_wdata are 0 while in IDLE after reset.

Decomposition:
- Package lsu_pkg:
  - state enum {IDLE, WAIT}
  - op-kind encoding {LD, ST}
  - default widths and the TIMEOUT default
- One sub-module, lsu_timeout_ctr: clear/enable counter with an expiry output, parameterised by TIMEOUT.

Test Plan:
- Load with ack 1 cycle after req: op_load, op_addr=16'h0105, op_rd=3, mem_rdata=16'hBEEF → mem_we=0, mem_addr=16'h0105; wb_valid pulses one cycle with wb_data=16'hBEEF, wb_reg=3; busy high exactly 1 cycle.
- Store with ack after 4 cycles: op_store, op_addr=16'hFFFF (ALU sum -1), op_wdata=16'h1234 → mem_we=1, mem_addr/mem_wdata stable for all 4 wait cycles; st_done one pulse; no wb_valid.
- Timeout: op_load, mem_ack held 0 → mem_req drops after 15 cycles, fault pulses once, wb_valid stays 0; the next op is accepted on the following edge.
- Illegal and ignored ops: op_valid with op_load=op_store=1 → fault pulse, mem_req never asserts; op_valid with both 0 → no activity. mem_ack pulsed in IDLE → no outputs.
- Reset mid-WAIT: assert rst_n=0 during a pending load → mem_req falls without a clock edge, all outputs 0; after release no wb_valid for the aborted load.
- Back-to-back plus ack-at-expiry: 200 loads with immediate ack and op_rd cycling 0..7 → 200 wb_valid pulses, each with correct data and register, one op per 2 cycles. One load acked exactly at cycle 15 → wb_valid, no fault.
